// File: rtl/pipe_pkg.sv
// Shared pipeline-control types: sequencer state encoding, register index
// width and the five-bit control-output bundle used by hazard_sequencer.
package pipe_pkg;

   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] ZERO_REG = '0;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      LDSTALL = 2'd1,
      FLUSH   = 2'd2
   } seq_state_e;

   // Field order fixes the bit order of the ctrl_t constants below.
   typedef struct packed {
      logic stall_mux;
      logic pc_write;
      logic if_id_write;
      logic if_id_flush;
      logic id_ex_flush;
   } ctrl_t;

   localparam ctrl_t CTRL_RUN      = ctrl_t'(5'b11100);
   localparam ctrl_t CTRL_STALL    = ctrl_t'(5'b00000);
   localparam ctrl_t CTRL_REDIRECT = ctrl_t'(5'b01011);
   localparam ctrl_t CTRL_FLUSH    = ctrl_t'(5'b01110);
   localparam ctrl_t CTRL_RESET    = ctrl_t'(5'b00011);

   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
      return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in EX and the instruction in ID.
module hazard_detect
   import pipe_pkg::*;
(
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rt,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   output logic             hazard
);

   // A load into $0 writes nothing, so it can never create a dependency.
   assign hazard = ex_mem_read && (ex_rt != ZERO_REG) &&
                   ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/hazard_sequencer.sv
// Stall/flush sequencer for the 5-stage core. Defining HAZARD_STATS_EN adds
// saturating stall/flush/bubble event counters as extra outputs.
module hazard_sequencer
   import pipe_pkg::*;
#(
   parameter int LOAD_USE_CYCLES = 1,
   parameter int FLUSH_CYCLES    = 1,
   parameter int CNT_W           = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rt,
   input  logic             redirect,
   output logic             stall_mux,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_flush
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]      stall_count,
   output logic [31:0]      flush_count,
   output logic [31:0]      bubble_count
`endif
);

   localparam logic [CNT_W-1:0] FL_RELOAD =
      (FLUSH_CYCLES > 0) ? CNT_W'(FLUSH_CYCLES - 1) : '0;
   localparam logic [CNT_W-1:0] LU_RELOAD =
      (LOAD_USE_CYCLES > 1) ? CNT_W'(LOAD_USE_CYCLES - 2) : '0;

   seq_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hazard;
   ctrl_t            ctrl;

   hazard_detect u_detect (
      .ex_mem_read (ex_mem_read),
      .ex_rt       (ex_rt),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rt  (id_uses_rt),
      .hazard      (hazard)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ctrl    = CTRL_RUN;
      // A redirect wins in every state: it aborts a stall and restarts a flush.
      if (redirect) begin
         ctrl = CTRL_REDIRECT;
         if (FLUSH_CYCLES > 0) begin
            state_d = FLUSH;
            cnt_d   = FL_RELOAD;
         end else begin
            state_d = RUN;
            cnt_d   = '0;
         end
      end else begin
         case (state_q)
            RUN: begin
               if (hazard) begin
                  ctrl = CTRL_STALL;
                  if (LOAD_USE_CYCLES > 1) begin
                     state_d = LDSTALL;
                     cnt_d   = LU_RELOAD;
                  end
               end
            end
            LDSTALL: begin
               ctrl = CTRL_STALL;
               if (cnt_q == '0) state_d = RUN;
               else             cnt_d   = cnt_q - CNT_W'(1);
            end
            FLUSH: begin
               ctrl = CTRL_FLUSH;
               if (cnt_q == '0) state_d = RUN;
               else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: begin
               state_d = RUN;
               cnt_d   = '0;
            end
         endcase
      end
      if (reset) ctrl = CTRL_RESET;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign stall_mux   = ctrl.stall_mux;
   assign pc_write    = ctrl.pc_write;
   assign if_id_write = ctrl.if_id_write;
   assign if_id_flush = ctrl.if_id_flush;
   assign id_ex_flush = ctrl.id_ex_flush;

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;
   logic [31:0] bubble_cnt_q, bubble_cnt_d;

   // Stall and redirect cycles have unique output patterns; reset's pattern differs from both.
   always_comb begin
      stall_cnt_d  = sat_inc(stall_cnt_q, ctrl == CTRL_STALL);
      flush_cnt_d  = sat_inc(flush_cnt_q, ctrl == CTRL_REDIRECT);
      bubble_cnt_d = sat_inc(bubble_cnt_q, !ctrl.stall_mux && !reset);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q  <= '0;
         flush_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign stall_count  = stall_cnt_q;
   assign flush_count  = flush_cnt_q;
   assign bubble_count = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench: the driver pushes per-cycle expectations from a
// remaining-bubble model; a monitor pops and compares them mid-cycle.
module tb_hazard_sequencer;

   localparam int LUC = 3;
   localparam int FC  = 1;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
   logic       id_uses_rt = 1'b0, ex_mem_read = 1'b0, redirect = 1'b0;
   logic       stall_mux, pc_write, if_id_write, if_id_flush, id_ex_flush;
`ifdef HAZARD_STATS_EN
   logic [31:0] stall_count, flush_count, bubble_count;
`endif

   always #5 clk = ~clk;

   hazard_sequencer #(.LOAD_USE_CYCLES(LUC), .FLUSH_CYCLES(FC), .CNT_W(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rt  (id_uses_rt),
      .ex_mem_read (ex_mem_read),
      .ex_rt       (ex_rt),
      .redirect    (redirect),
      .stall_mux   (stall_mux),
      .pc_write    (pc_write),
      .if_id_write (if_id_write),
      .if_id_flush (if_id_flush),
      .id_ex_flush (id_ex_flush)
`ifdef HAZARD_STATS_EN
      ,
      .stall_count (stall_count),
      .flush_count (flush_count),
      .bubble_count(bubble_count)
`endif
   );

   typedef struct {
      logic [4:0]  ctrl;  // {stall_mux, pc_write, if_id_write, if_id_flush, id_ex_flush}
      int unsigned sc, fc, bc;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0, passed = 0;
   int          ld_left = 0, fl_left = 0;
   int unsigned m_sc = 0, m_fc = 0, m_bc = 0;

   // One cycle of stimulus plus the reference expectation for that cycle.
   task automatic drive(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                        input logic ur, input logic mr, input logic [4:0] ert,
                        input logic rd);
      exp_t e;
      logic hz;
      logic [4:0] c;
      @(posedge clk); #1;
      reset = r; id_rs = rs; id_rt = rt; id_uses_rt = ur;
      ex_mem_read = mr; ex_rt = ert; redirect = rd;
      e.sc = m_sc; e.fc = m_fc; e.bc = m_bc;
      hz = mr && (ert != 5'd0) && ((ert == rs) || (ur && (ert == rt)));
      if (r) begin
         c = 5'b00011; ld_left = 0; fl_left = 0;
      end else if (rd) begin
         c = 5'b01011; fl_left = FC; ld_left = 0;
      end else if (fl_left > 0) begin
         c = 5'b01110; fl_left--;
      end else if (ld_left > 0) begin
         c = 5'b00000; ld_left--;
      end else if (hz) begin
         c = 5'b00000; ld_left = LUC - 1;
      end else begin
         c = 5'b11100;
      end
      if (r) begin
         m_sc = 0; m_fc = 0; m_bc = 0;
      end else begin
         if (c == 5'b00000) m_sc++;
         if (rd) m_fc++;
         if (!c[4]) m_bc++;
      end
      e.ctrl = c;
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
   endtask

   initial begin : monitor
      exp_t e;
      logic [4:0] got;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            got = {stall_mux, pc_write, if_id_write, if_id_flush, id_ex_flush};
            checks++;
            if (got == e.ctrl) passed++;
            else $display("FAIL ctrl t=%0t got=%b exp=%b", $time, got, e.ctrl);
`ifdef HAZARD_STATS_EN
            checks++;
            if (stall_count == e.sc && flush_count == e.fc && bubble_count == e.bc) passed++;
            else $display("FAIL stats t=%0t got=%0d/%0d/%0d exp=%0d/%0d/%0d", $time,
                          stall_count, flush_count, bubble_count, e.sc, e.fc, e.bc);
`endif
         end
      end
   end

   initial begin
      drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      idle(2);
      // load-use on rs
      drive(1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
      idle(4);
      // rt not read, and $0 destination: no stall
      drive(1'b0, 5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0);
      drive(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0);
      // load-use on rt
      drive(1'b0, 5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0);
      idle(3);
      // plain redirect
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
      idle(3);
      // hazard and redirect together
      drive(1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1);
      idle(3);
      // redirect in second stall cycle aborts the stall
      drive(1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
      idle(3);
      // hazard held during FLUSH is ignored; redirect in FLUSH restarts
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
      drive(1'b0, 5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0);
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
      idle(2);
      // reset in FLUSH and in LDSTALL
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
      drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      idle(2);
      drive(1'b0, 5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0);
      drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      idle(2);
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 49) == 0),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0));
      end
      idle(1);
      repeat (3) @(posedge clk);
      checks++;
      if (sb.size() == 0) passed++;
      else $display("FAIL drain got=%0d entries exp=0", sb.size());
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Pipeline hazard and flow controller for the 5-stage MIPS core.
- Detects load-use hazards in ID and takes branch/jump redirects from EX.
- Sequences stall and flush cycles, and drives stall_mux into control_mux (0 = decode a NOP bubble).
- Drives PC and IF/ID write enables and the IF/ID and ID/EX flush strobes.

Parameters:
- LOAD_USE_CYCLES, 1, bubble cycles inserted per load-use hazard (range 1..3).
- FLUSH_CYCLES, 1, extra bubble cycles after the redirect cycle (range 0..3).
- CNT_W, 2, width of the internal cycle counter.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  the ID instruction reads rt (R-type, branch, store).
- ex_mem_read  in  1  the EX instruction is a load (MemRead_out registered into ID/EX).
- ex_rt  in  5  destination rt of the EX instruction.
- redirect  in  1  taken branch or jump resolved in EX (Branch & condition, or Jump).
- stall_mux  out  1  1 = normal decode, 0 = force control_mux to a NOP.
- pc_write  out  1  PC register load enable.
- if_id_write  out  1  IF/ID register load enable.
- if_id_flush  out  1  clear IF/ID to a NOP.
- id_ex_flush  out  1  clear ID/EX control bits.

Behaviour:
- States: RUN, LDSTALL, FLUSH. State is held in a register; cnt is CNT_W bits.
- hazard = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))).
  - Evaluated only in RUN. It is combinational, so it acts in the same cycle.
- Reset (reset=1 at the edge):
  - state <= RUN, cnt <= 0.
  - While reset is high, outputs are forced: stall_mux=0, pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1.
- RUN, redirect=1:
  - Has priority over hazard.
  - Outputs this cycle: pc_write=1 (loads the target), if_id_write=0, if_id_flush=1, id_ex_flush=1, stall_mux=0.
  - If FLUSH_CYCLES>0, go to FLUSH with cnt <= FLUSH_CYCLES-1; otherwise stay in RUN.
- RUN, hazard=1, redirect=0:
  - Outputs this cycle: pc_write=0, if_id_write=0, stall_mux=0, id_ex_flush=0, if_id_flush=0.
  - If LOAD_USE_CYCLES>1, go to LDSTALL with cnt <= LOAD_USE_CYCLES-2; otherwise stay in RUN.
- RUN, otherwise: stall_mux=1, pc_write=1, if_id_write=1, both flushes 0.
- LDSTALL:
  - Outputs are the same as a RUN hazard cycle. cnt decrements each cycle.
  - At cnt==0, return to RUN on the next edge.
  - redirect=1 in LDSTALL: behaves exactly as a RUN redirect (abort the stall, enter FLUSH or RUN). The pending load-use is discarded.
- FLUSH:
  - Outputs: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=0, stall_mux=0.
  - cnt decrements each cycle; at cnt==0, go to RUN.
  - A hazard in FLUSH is ignored (the younger instruction is being squashed).
  - A redirect in FLUSH restarts the redirect cycle: same outputs as a RUN redirect, cnt reloads to FLUSH_CYCLES-1.
- Register $0 as a load destination never stalls.
- Reset mid-LDSTALL or mid-FLUSH aborts immediately; the next cycle is RUN with no residual bubble.
- Latency: zero-cycle combinational response to hazard/redirect; state update one cycle later.

Optional Feature:
- Macro HAZARD_STATS_EN.
- When defined, adds three outputs:
  - stall_count (32-bit): increments on each cycle in which a load-use stall is output.
  - flush_count (32-bit): increments on each redirect cycle.
  - bubble_count (32-bit): increments every cycle stall_mux=0 while reset=0.
- All three counters are cleared by reset and saturate at 32'hFFFFFFFF.
- When undefined, the ports and counters do not exist and the logic is identical otherwise.

Decomposition:
- Shared package pipe_pkg holds:
  - the state encoding (RUN=2'd0, LDSTALL=2'd1, FLUSH=2'd2);
  - register-index width REG_W=5 and the ZERO_REG constant.
- One natural sub-module: hazard_detect, a pure combinational compare producing hazard. It is reused later by the forwarding unit.

Test Plan:
- Load-use on rs: EX lw ex_rt=5, ID id_rs=5 -> one cycle with stall_mux=0, pc_write=0, if_id_write=0, then RUN with all enables 1.
- rt with id_uses_rt=0: ex_rt=7, id_rt=7, id_uses_rt=0 -> no stall. $0 destination: ex_rt=0, id_rs=0 -> no stall.
- Redirect with FLUSH_CYCLES=1: redirect pulse -> cycle0 pc_write=1, both flushes=1; cycle1 if_id_flush=1, stall_mux=0; cycle2 RUN.
- Simultaneous events: hazard and redirect in the same cycle -> redirect outputs, no LDSTALL. With LOAD_USE_CYCLES=3, redirect in the second stall cycle -> FLUSH entered, stall aborted.
- Reset in FLUSH: reset=1 for one cycle -> outputs forced to their reset values, then RUN with stall_mux=1 on the next cycle.
- HAZARD_STATS_EN: 3 load-use stalls and 2 redirects (FLUSH_CYCLES=1) -> stall_count=3, flush_count=2, bubble_count=7.
